// File: rtl/lane_word_serializer.sv
// Lane word serializer: captures a packed frame of NWORDS words and emits
// them one per handshake, highest-indexed word first, ending on word 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   load_valid/ready    frame offer handshake (ready only while idle)
//   load_data           packed frame, word NWORDS-1 in the MSBs
//   out_valid/ready     word handshake toward the downstream stage
//   out_data            current word, muxed from the frame register
//   out_idx, out_last   current word index; last marks word 0
//   flush               synchronous abort back to idle
//   frame_cnt           completed-frame counter, wraps at 256

module lane_word_serializer #(
    parameter int NWORDS = 5,
    parameter int WBITS  = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [NWORDS*WBITS-1:0] load_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WBITS-1:0]        out_data,
    output logic [2:0]              out_idx,
    output logic                    out_last,
    input  logic                    flush,
    output logic [7:0]              frame_cnt
);

    localparam logic [2:0] IDX_TOP = 3'(NWORDS - 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                    state;
    state_t                    state_nx;
    logic [NWORDS*WBITS-1:0]   frame;
    logic [2:0]                idx;
    logic [7:0]                cnt;

    logic                      cap;
    logic                      adv;
    logic                      fin;
    logic [WBITS-1:0]          word;

    // Next-state and datapath strobes.
    // flush dominates every other event in either state.
    always_comb begin
        state_nx = state;
        cap      = 1'b0;
        adv      = 1'b0;
        fin      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!flush && load_valid) begin
                    cap      = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (out_ready) begin
                    if (idx == 3'd0) begin
                        fin      = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Frame register only loads on capture, so it is frozen during SEND.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame <= '0;
            idx   <= 3'd0;
            cnt   <= 8'd0;
        end else begin
            if (cap) begin
                frame <= load_data;
                idx   <= IDX_TOP;
            end
            if (adv) begin
                idx <= idx - 3'd1;
            end
            if (fin) begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // Word select from the registered frame; no path from load_data.
    always_comb begin
        word = '0;
        for (int i = 0; i < NWORDS; i++) begin
            if (idx == 3'(i)) begin
                word = frame[i*WBITS +: WBITS];
            end
        end
    end

    assign load_ready = (state == IDLE);
    assign out_valid  = (state == SEND);
    assign out_last   = (state == SEND) && (idx == 3'd0);
    assign out_data   = word;
    assign out_idx    = idx;
    assign frame_cnt  = cnt;

endmodule

// File: tb/tb_lane_word_serializer.sv
// Self-checking bench for lane_word_serializer: scoreboard of expected
// words filled at capture time and drained as the DUT transfers words.

module tb_lane_word_serializer;

    localparam int N = 5;
    localparam int W = 10;

    typedef struct packed {
        logic [W-1:0] d;
        logic [2:0]   i;
        logic         l;
    } exp_t;

    logic           clk;
    logic           rst_n;
    logic           load_valid;
    logic           load_ready;
    logic [N*W-1:0] load_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [2:0]     out_idx;
    logic           out_last;
    logic           flush;
    logic [7:0]     frame_cnt;

    exp_t       q[$];
    logic [7:0] exp_cnt;
    int         checks;
    int         errors;

    localparam logic [N*W-1:0] F0 =
        {10'h3FF, 10'h001, 10'h155, 10'h2AA, 10'h000};

    lane_word_serializer #(
        .NWORDS(N),
        .WBITS (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .flush     (flush),
        .frame_cnt (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [N*W-1:0] f);
        exp_t e;
        for (int k = N - 1; k >= 0; k--) begin
            e.d = f[k*W +: W];
            e.i = 3'(k);
            e.l = (k == 0);
            q.push_back(e);
        end
    endtask

    task automatic test_reset;
        exp_t e;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        out_ready  = 1'b1;
        flush      = 1'b0;
        exp_cnt    = 8'd0;
        #3;
        checks++;
        if ({out_valid, out_data, out_idx, out_last, load_ready, frame_cnt}
            !== {1'b0, 10'h0, 3'd0, 1'b0, 1'b1, 8'd0}) begin
            errors++;
            $display("FAIL reset_state act v=%b d=%h i=%0d l=%b r=%b c=%0d req 0 0 0 0 1 0",
                     out_valid, out_data, out_idx, out_last, load_ready, frame_cnt);
        end
        @(posedge clk);
        #1;
        load_data  = F0;
        load_valid = 1'b1;
        push_frame(F0);
        #6;
        rst_n = 1'b1;
        step();
        load_valid = 1'b0;
        for (int c = 0; c < N; c++) begin
            e = q.pop_front();
            checks++;
            if ({out_valid, out_data, out_idx, out_last} !== {1'b1, e}) begin
                errors++;
                $display("FAIL first_capture act v=%b d=%h i=%0d l=%b req d=%h i=%0d l=%b",
                         out_valid, out_data, out_idx, out_last, e.d, e.i, e.l);
            end
            if (e.l) exp_cnt++;
            step();
        end
    endtask

    task automatic test_frame;
        exp_t e;
        out_ready = 1'b1;
        checks++;
        if (load_ready !== 1'b1) begin
            errors++;
            $display("FAIL frame_ready act=%b req=1", load_ready);
        end
        load_data  = F0;
        load_valid = 1'b1;
        push_frame(F0);
        step();
        load_valid = 1'b0;
        for (int c = 0; c < N; c++) begin
            e = q.pop_front();
            checks++;
            if ({out_valid, out_data, out_idx, out_last} !== {1'b1, e}) begin
                errors++;
                $display("FAIL frame_word act v=%b d=%h i=%0d l=%b req d=%h i=%0d l=%b",
                         out_valid, out_data, out_idx, out_last, e.d, e.i, e.l);
            end
            if (e.l) exp_cnt++;
            step();
        end
        checks++;
        if ({out_valid, load_ready, frame_cnt} !== {1'b0, 1'b1, exp_cnt}) begin
            errors++;
            $display("FAIL frame_end act v=%b r=%b c=%0d req v=0 r=1 c=%0d",
                     out_valid, load_ready, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_backpressure;
        exp_t e;
        int   hold;
        int   cyc;
        hold       = 0;
        cyc        = 0;
        load_data  = F0;
        load_valid = 1'b1;
        push_frame(F0);
        step();
        load_valid = 1'b0;
        load_data  = ~F0;
        while (q.size() != 0 && cyc < 30) begin
            if (out_idx == 3'd2 && hold < 3) begin
                out_ready = 1'b0;
                hold++;
            end else begin
                out_ready = 1'b1;
            end
            e = q[0];
            checks++;
            if ({out_valid, out_data, out_idx, out_last} !== {1'b1, e}) begin
                errors++;
                $display("FAIL bp_word act v=%b d=%h i=%0d l=%b req d=%h i=%0d l=%b",
                         out_valid, out_data, out_idx, out_last, e.d, e.i, e.l);
            end
            if (out_ready) begin
                void'(q.pop_front());
                if (e.l) exp_cnt++;
            end
            step();
            cyc++;
        end
        out_ready = 1'b1;
        checks++;
        if (q.size() != 0 || hold != 3) begin
            errors++;
            $display("FAIL bp_drain act left=%0d hold=%0d req left=0 hold=3",
                     q.size(), hold);
            q.delete();
        end
        checks++;
        if ({out_valid, frame_cnt} !== {1'b0, exp_cnt}) begin
            errors++;
            $display("FAIL bp_end act v=%b c=%0d req v=0 c=%0d",
                     out_valid, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_flush;
        exp_t e;
        for (int pass = 0; pass < 2; pass++) begin
            out_ready  = 1'b1;
            load_data  = F0 ^ 50'h15555_5555_5555;
            load_valid = 1'b1;
            push_frame(load_data);
            step();
            load_valid = 1'b0;
            while (out_idx != 3'(pass == 0 ? 1 : 0) && q.size() != 0) begin
                e = q.pop_front();
                checks++;
                if ({out_valid, out_data, out_idx, out_last} !== {1'b1, e}) begin
                    errors++;
                    $display("FAIL flush_word act v=%b d=%h i=%0d l=%b req d=%h i=%0d l=%b",
                             out_valid, out_data, out_idx, out_last, e.d, e.i, e.l);
                end
                step();
            end
            flush = 1'b1;
            step();
            flush = 1'b0;
            q.delete();
            checks++;
            if ({out_valid, load_ready, frame_cnt} !== {1'b0, 1'b1, exp_cnt}) begin
                errors++;
                $display("FAIL flush_idle%0d act v=%b r=%b c=%0d req v=0 r=1 c=%0d",
                         pass, out_valid, load_ready, frame_cnt, exp_cnt);
            end
        end
        load_valid = 1'b1;
        flush      = 1'b1;
        step();
        load_valid = 1'b0;
        flush      = 1'b0;
        checks++;
        if ({out_valid, load_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_blocks_cap act v=%b r=%b req v=0 r=1",
                     out_valid, load_ready);
        end
    endtask

    task automatic test_wrap;
        exp_t       e;
        logic [7:0] start;
        int         done;
        int         cyc;
        start      = exp_cnt;
        done       = 0;
        cyc        = 0;
        load_valid = 1'b1;
        while (done < 256 && cyc < 8000) begin
            checks++;
            if (frame_cnt !== exp_cnt) begin
                errors++;
                $display("FAIL wrap_cnt act=%0d req=%0d", frame_cnt, exp_cnt);
            end
            load_data = {$urandom, $urandom};
            out_ready = ($urandom_range(0, 3) != 0);
            if (load_ready) push_frame(load_data);
            if (out_valid) begin
                e = q[0];
                checks++;
                if ({out_data, out_idx, out_last} !== e) begin
                    errors++;
                    $display("FAIL wrap_word act d=%h i=%0d l=%b req d=%h i=%0d l=%b",
                             out_data, out_idx, out_last, e.d, e.i, e.l);
                end
                if (out_ready) begin
                    void'(q.pop_front());
                    if (e.l) begin
                        exp_cnt++;
                        done++;
                    end
                end
            end
            step();
            cyc++;
        end
        load_valid = 1'b0;
        out_ready  = 1'b1;
        checks++;
        if (done != 256 || q.size() != 0) begin
            errors++;
            $display("FAIL wrap_timeout act done=%0d left=%0d req done=256 left=0",
                     done, q.size());
            q.delete();
        end
        checks++;
        if (frame_cnt !== start) begin
            errors++;
            $display("FAIL wrap_final act=%0d req=%0d", frame_cnt, start);
        end
    endtask

    task automatic test_mid_reset;
        exp_t e;
        out_ready  = 1'b1;
        load_data  = F0;
        load_valid = 1'b1;
        push_frame(F0);
        step();
        load_valid = 1'b0;
        e = q.pop_front();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_cnt = 8'd0;
        checks++;
        if ({out_valid, frame_cnt, load_ready, out_last, out_idx, out_data}
            !== {1'b0, 8'd0, 1'b1, 1'b0, 3'd0, 10'h0}) begin
            errors++;
            $display("FAIL mid_reset act v=%b c=%0d r=%b l=%b i=%0d d=%h req 0 0 1 0 0 0",
                     out_valid, frame_cnt, load_ready, out_last, out_idx, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle act=%b req=0", out_valid);
            end
            step();
        end
        load_data  = {10'h123, 10'h0AB, 10'h3C0, 10'h00F, 10'h2F1};
        load_valid = 1'b1;
        push_frame(load_data);
        step();
        load_valid = 1'b0;
        for (int c = 0; c < N; c++) begin
            e = q.pop_front();
            checks++;
            if ({out_valid, out_data, out_idx, out_last} !== {1'b1, e}) begin
                errors++;
                $display("FAIL post_reset_word act v=%b d=%h i=%0d l=%b req d=%h i=%0d l=%b",
                         out_valid, out_data, out_idx, out_last, e.d, e.i, e.l);
            end
            if (e.l) exp_cnt++;
            step();
        end
        checks++;
        if ({out_valid, frame_cnt} !== {1'b0, exp_cnt}) begin
            errors++;
            $display("FAIL post_reset_cnt act v=%b c=%0d req v=0 c=%0d",
                     out_valid, frame_cnt, exp_cnt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_frame();
        test_backpressure();
        test_flush();
        test_wrap();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_word_serializer.md
LANE_WORD_SERIALIZER -- requirements
Module: lane_word_serializer

Interface
REQ-001 The block SHALL have parameter NWORDS, default 5, number of words per frame (2..8).
REQ-002 The block SHALL have parameter WBITS, default 10, width of each word in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with ports as below.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 load_valid  input  1  a frame is offered on load_data.
REQ-007 load_ready  output  1  the block can accept a frame.
REQ-008 load_data  input  NWORDS*WBITS  packed frame; word NWORDS-1 in the MSBs, word 0 in the LSBs.
REQ-009 out_valid  output  1  out_data holds a valid word.
REQ-010 out_ready  input  1  the downstream stage accepts the word.
REQ-011 out_data  output  WBITS  current word.
REQ-012 out_idx  output  3  index of the current word within the frame.
REQ-013 out_last  output  1  current word is word 0, the final word of the frame.
REQ-014 flush  input  1  synchronous abort of the frame in progress.
REQ-015 frame_cnt  output  8  count of frames completed.

Function
REQ-016 The block SHALL implement two states: IDLE and SEND.
REQ-017 In IDLE, load_ready SHALL be 1; in SEND, load_ready SHALL be 0 (no back-to-back capture).
REQ-018 On an edge with load_valid=1 and load_ready=1 (and flush=0), the block SHALL capture load_data, set out_idx=NWORDS-1 and enter SEND.
REQ-019 Word ordering: word NWORDS-1 SHALL be sent first, then descending to word 0.
REQ-020 Capture-to-output latency SHALL be 1 cycle: out_valid=1 in the cycle after the capture edge.
REQ-021 out_valid SHALL be 1 exactly when the state is SEND.
REQ-022 out_data SHALL equal the captured word[out_idx], driven from registers (no combinational path from load_data).
REQ-023 A word is transferred on an edge with out_valid=1 and out_ready=1; out_idx SHALL then decrement by 1.
REQ-024 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable.
REQ-025 out_last SHALL be 1 exactly when state=SEND and out_idx=0.
REQ-026 When a transfer occurs with out_last=1, the block SHALL return to IDLE and increment frame_cnt by 1.
REQ-027 frame_cnt SHALL wrap from 255 to 0 with no saturation or flag.
REQ-028 When flush=1 at an edge, the block SHALL enter IDLE regardless of state or handshakes.
REQ-029 A flush SHALL not increment frame_cnt, including when out_last=1 and out_ready=1 in the same cycle.
REQ-030 flush=1 in IDLE SHALL block a capture in the same cycle, and load_valid SHALL be ignored.
REQ-031 The captured frame register SHALL not change during SEND, whatever load_data does.

Reset
REQ-032 While rst_n=0, the block SHALL force state=IDLE, out_valid=0, out_idx=0, out_data=0, the frame register to 0 and frame_cnt=0.
REQ-033 Reset SHALL take effect immediately, without a clock edge.
REQ-034 Outputs during reset SHALL be: load_ready=1, out_last=0.
REQ-035 Reset asserted mid-frame SHALL discard the frame, and no partial words SHALL appear after release.
REQ-036 The first capture SHALL be possible at the first rising edge after rst_n deasserts.

Verification
REQ-037 Frame test (out_ready=1, defaults): load words 4..0 = 3FF, 001, 155, 2AA, 000 (hex). Required: out_data = 3FF, 001, 155, 2AA, 000 on consecutive cycles; out_idx 4..0; out_last only on 000; frame_cnt 0->1; load_ready returns to 1.
REQ-038 Backpressure test: hold out_ready=0 for 3 cycles at idx 2. Required: out_data=155 and out_idx=2 stable, then the sequence resumes with no loss or duplication.
REQ-039 Flush test: assert flush at idx 1 with out_ready=1. Required: IDLE next cycle, out_valid=0, frame_cnt unchanged. Repeat the test with flush coincident with the out_last transfer; frame_cnt SHALL remain unchanged.
REQ-040 Wrap test: send 256 frames. Required: frame_cnt returns to 0. Also, load_valid held high during SEND SHALL NOT recapture (the output sequence stays that of the original frame).
REQ-041 Reset test: assert rst_n=0 at idx 3 between clock edges. Required: immediately out_valid=0 and frame_cnt=0; after release, out_valid stays 0 until a new capture.
